// File: rtl/rst_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rst_seq_pkg                                                 |
// | Purpose  : Shared definitions for the reset sequencer: the seq_state   |
// |            encoding (also decoded by debug/LED logic) and a small      |
// |            helper used to size the shared hold/timeout counter.        |
// | Ports    : none (package)                                              |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package rst_seq_pkg;

   localparam int SEQ_STATE_W = 3;

   // Encodings are visible on the debug LEDs, so they are fixed, not tool-chosen.
   typedef enum logic [SEQ_STATE_W-1:0] {
      ST_HOLD      = 3'd0,
      ST_WAIT_CAL  = 3'd1,
      ST_IO_WAIT   = 3'd2,
      ST_CORE_WAIT = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAULT     = 3'd7
   } seq_state_t;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rst_seq_if                                                  |
// | Purpose  : Bundle of the sequencer's domain resets, calibration        |
// |            handshake and debug state.                                  |
// | Signals  : mem_calib_done  calibration complete (to sequencer)         |
// |            mem_rstn/io_rstn/core_rstn  active-low domain resets        |
// |            calib_err       sticky calibration timeout flag             |
// |            seq_state       current sequencer state (debug LEDs)        |
// | Modports : master = sequencer side, slave = system side                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface rst_seq_if;
   import rst_seq_pkg::*;

   logic                   mem_calib_done;
   logic                   mem_rstn;
   logic                   io_rstn;
   logic                   core_rstn;
   logic                   calib_err;
   logic [SEQ_STATE_W-1:0] seq_state;

   modport master (
      input  mem_calib_done,
      output mem_rstn, io_rstn, core_rstn, calib_err, seq_state
   );

   modport slave (
      output mem_calib_done,
      input  mem_rstn, io_rstn, core_rstn, calib_err, seq_state
   );

endinterface
`default_nettype wire

// File: rtl/rst_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rst_sync                                                    |
// | Purpose  : Reset synchronizer, asynchronous assertion / synchronous    |
// |            deassertion. rstn_out rises on the STAGES-th rising clk     |
// |            edge after rstn_in rises; falls immediately with rstn_in.   |
// | Ports    : clk      in  clock of the destination domain               |
// |            rstn_in  in  asynchronous active-low reset                 |
// |            rstn_out out synchronized active-low reset                 |
// | Params   : STAGES   flop count in the chain (>=2)                     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module rst_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn_in,
   output logic rstn_out
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk or negedge rstn_in) begin
      if (!rstn_in) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], 1'b1};
      end
   end

   assign rstn_out = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : rst_seq                                                     |
// | Purpose  : Synchronizes the board reset and releases the memory, I/O   |
// |            and core reset domains in order. I/O and core release is    |
// |            gated on memory calibration; a calibration timeout parks    |
// |            the sequencer in FAULT with calib_err set until rstn.       |
// | Ports    : clk   in  system clock                                     |
// |            rstn  in  asynchronous active-low reset                    |
// |            bus   rst_seq_if.master: mem_calib_done in; mem_rstn,      |
// |                  io_rstn, core_rstn, calib_err, seq_state out         |
// | Params   : SYNC_STAGES, MEM_HOLD, IO_HOLD, CORE_HOLD, CALIB_TIMEOUT   |
// |            (CALIB_TIMEOUT = 0 waits for calibration forever)          |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int MEM_HOLD      = 16,
   parameter int IO_HOLD       = 16,
   parameter int CORE_HOLD     = 16,
   parameter int CALIB_TIMEOUT = 2**20
) (
   input  logic      clk,
   input  logic      rstn,
   rst_seq_if.master bus
);

   // Counter holds N-1 on state entry and the state acts when it reads zero,
   // so an N-cycle hold finishes on the N-th edge in that state.
   localparam int CNT_MAX = max_of(max_of(MEM_HOLD, IO_HOLD),
                                   max_of(CORE_HOLD, CALIB_TIMEOUT));
   localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] C_LD_MEM  = CNT_W'(MEM_HOLD - 1);
   localparam logic [CNT_W-1:0] C_LD_IO   = CNT_W'(IO_HOLD - 1);
   localparam logic [CNT_W-1:0] C_LD_CORE = CNT_W'(CORE_HOLD - 1);
   localparam logic [CNT_W-1:0] C_LD_CAL  =
      CNT_W'((CALIB_TIMEOUT == 0) ? 0 : CALIB_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

   logic             w_rstn_s;
   seq_state_t       r_state, w_state_n;
   logic [CNT_W-1:0] r_cnt,   w_cnt_n;
   logic             r_mem,   w_mem_n;
   logic             r_io,    w_io_n;
   logic             r_core,  w_core_n;
   logic             r_err,   w_err_n;
   logic             w_expired;
   logic             w_cal;

   rst_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rstn_in  (rstn),
      .rstn_out (w_rstn_s)
   );

   assign w_expired = (r_cnt == '0);
   assign w_cal     = bus.mem_calib_done;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_HOLD;
         r_cnt   <= C_LD_MEM;
         r_mem   <= 1'b0;
         r_io    <= 1'b0;
         r_core  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         r_mem   <= w_mem_n;
         r_io    <= w_io_n;
         r_core  <= w_core_n;
         r_err   <= w_err_n;
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      w_mem_n   = r_mem;
      w_io_n    = r_io;
      w_core_n  = r_core;
      w_err_n   = r_err;

      if (!w_rstn_s) begin
         // Synchronizer still low: park in HOLD with a fresh memory hold.
         w_state_n = ST_HOLD;
         w_cnt_n   = C_LD_MEM;
         w_mem_n   = 1'b0;
         w_io_n    = 1'b0;
         w_core_n  = 1'b0;
         w_err_n   = 1'b0;
      end else begin
         unique case (r_state)
            ST_HOLD: begin
               if (w_expired) begin
                  w_state_n = ST_WAIT_CAL;
                  w_cnt_n   = C_LD_CAL;
                  w_mem_n   = 1'b1;
               end else begin
                  w_cnt_n = r_cnt - C_ONE;
               end
            end
            ST_WAIT_CAL: begin
               // Calibration is tested first so it wins a same-cycle timeout.
               if (w_cal) begin
                  w_state_n = ST_IO_WAIT;
                  w_cnt_n   = C_LD_IO;
               end else if (CALIB_TIMEOUT != 0) begin
                  if (w_expired) begin
                     w_state_n = ST_FAULT;
                     w_err_n   = 1'b1;
                  end else begin
                     w_cnt_n = r_cnt - C_ONE;
                  end
               end
            end
            ST_IO_WAIT, ST_CORE_WAIT, ST_RUN: begin
               if (!w_cal) begin
                  // Calibration lost: pull I/O and core back into reset and
                  // wait for calibration again with a full timeout window.
                  w_state_n = ST_WAIT_CAL;
                  w_cnt_n   = C_LD_CAL;
                  w_io_n    = 1'b0;
                  w_core_n  = 1'b0;
               end else if (r_state == ST_IO_WAIT) begin
                  if (w_expired) begin
                     w_state_n = ST_CORE_WAIT;
                     w_cnt_n   = C_LD_CORE;
                     w_io_n    = 1'b1;
                  end else begin
                     w_cnt_n = r_cnt - C_ONE;
                  end
               end else if (r_state == ST_CORE_WAIT) begin
                  if (w_expired) begin
                     w_state_n = ST_RUN;
                     w_core_n  = 1'b1;
                  end else begin
                     w_cnt_n = r_cnt - C_ONE;
                  end
               end
            end
            ST_FAULT: begin
               // Terminal until rstn; outputs simply hold.
            end
            default: begin
               w_state_n = ST_HOLD;
               w_cnt_n   = C_LD_MEM;
               w_mem_n   = 1'b0;
               w_io_n    = 1'b0;
               w_core_n  = 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_rstn  = r_mem;
   assign bus.io_rstn   = r_io;
   assign bus.core_rstn = r_core;
   assign bus.calib_err = r_err;
   assign bus.seq_state = r_state;

endmodule
`default_nettype wire
